dpram_be: RTL and testbench
===========================

DPRAM_BE -- requirements
Module: dpram_be

Interface
REQ-001 Parameter DATA, default 32, word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR, default 5, address width; depth = 2^ADDR words.
REQ-003 Parameter OUT_REG, default 0, read latency select: 0 = 1 cycle, 1 = 2 cycles (extra output register).
REQ-004 Parameter RDW_MODE, default 0, same-port read-during-write: 0 = read-first (old word), 1 = write-first (new merged word).
REQ-005 clK  in  1  single clock; all state on its rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 a_port_EN  in  1  port A access request.
REQ-008 a_port_WR  in  1  port A write qualifier (valid only with EN).
REQ-009 a_port_BE  in  DATA/8  port A byte-write enables; bit i covers bits 8i+7:8i.
REQ-010 a_port_ADDR  in  ADDR  port A word address.
REQ-011 a_port_data_IN  in  DATA  port A write data.
REQ-012 a_port_data_OUT  out  DATA  port A read data.
REQ-013 a_port_VLD  out  1  port A read-data-valid strobe.
REQ-014 b_port_EN, b_port_WR, b_port_BE, b_port_ADDR, b_port_data_IN, b_port_data_OUT, b_port_VLD: port B, same widths and meanings as port A.
REQ-015 clr_REQ  in  1  request to zero the whole array.
REQ-016 clr_BUSY  out  1  clear sweep in progress.
REQ-017 coll_FLAG  out  1  cross-port address collision strobe (present only per REQ-035).

Function
REQ-018 Access on a port: EN=1 and clr_BUSY=0 at the clock edge; otherwise the port is idle.
REQ-019 Write access (WR=1): only bytes with BE=1 updated at that edge; BE=0 bytes retained; WR=1 with BE=0 is a read access for VLD purposes.
REQ-020 Every access (read or write) returns a word: data_OUT and VLD=1 after 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1); VLD is a 1-cycle pulse per access, back-to-back accesses give continuous VLD.
REQ-021 data_OUT holds its last value when no VLD is issued.
REQ-022 Same-port write: returned word per RDW_MODE (0: pre-write word; 1: word after byte merge).
REQ-023 Cross-port collision: both ports access the same ADDR in one cycle with at least one WR=1.
REQ-024 Collision, both write: bytes enabled on both ports take port A data; bytes enabled on one port only take that port's data.
REQ-025 Collision, one reads: reading port returns the pre-write word regardless of RDW_MODE.
REQ-026 Clear FSM states IDLE, SWEEP; IDLE -> SWEEP on clr_REQ=1; clr_BUSY=1 from the following cycle.
REQ-027 SWEEP writes zero to addresses 0,1,...,2^ADDR-1, one per cycle, then returns to IDLE; clr_BUSY high for exactly 2^ADDR cycles.
REQ-028 clr_REQ ignored while in SWEEP; clr_REQ held high after sweep end starts a new sweep.
REQ-029 Port requests during clr_BUSY=1 are discarded (no write, no VLD); reads issued before SWEEP entry complete normally with pre-clear data.
REQ-030 clr_REQ and port accesses in the same IDLE cycle: port accesses complete, sweep starts next cycle.

Reset
REQ-031 rst=1 asynchronously forces a_port_data_OUT, b_port_data_OUT = 0, a_port_VLD, b_port_VLD = 0, clr_BUSY = 0, coll_FLAG = 0, FSM = IDLE, sweep counter = 0, pipeline registers = 0.
REQ-032 Array contents not affected by reset; reset mid-sweep aborts it, leaving addresses already swept at zero and the rest unchanged.
REQ-033 Accesses resume on the first clock edge after rst deasserts.

Configuration
REQ-034 Macro DPRAM_BE_COLL_DET_EN selects collision reporting.
REQ-035 Defined: coll_FLAG present, pulses 1 for one cycle, one cycle after each collision (REQ-023). Undefined: port omitted; REQ-024/REQ-025 arbitration unchanged.

Verification
REQ-036 DATA=32, ADDR=5, OUT_REG=0: A writes 0xDEADBEEF to 3, BE=0xF; next cycle A reads 3 -> data_OUT=0xDEADBEEF with VLD one cycle later.
REQ-037 Word 3=0xDEADBEEF; A writes 0x11223344, BE=0x5, to 3, RDW_MODE=0 -> returns 0xDEADBEEF; read-back 0xDE22BE44; with RDW_MODE=1 write returns 0xDE22BE44.
REQ-038 Word 7=0; A writes 0xAAAAAAAA BE=0x3, B writes 0xBBBBBBBB BE=0x6 same cycle -> word 7=0x00BBAAAA, coll_FLAG pulses next cycle (macro defined).
REQ-039 OUT_REG=1: reads of addresses 0..3 on four consecutive cycles -> VLD high four cycles, first data two cycles after first request, in order.
REQ-040 Fill all 32 words nonzero, pulse clr_REQ -> clr_BUSY high 32 cycles, port requests ignored, then all words read 0; repeat with rst after 10 sweep cycles -> words 0..9 zero, 10..31 unchanged, clr_BUSY=0.

Source files
------------

// File: rtl/dpram_be.sv
// True dual-port RAM with byte-write enables, configurable read latency and
// read-during-write order, and a background clear sweep. Define
// DPRAM_BE_COLL_DET_EN to add the coll_FLAG cross-port collision strobe.
module dpram_be #(
  parameter int DATA     = 32,
  parameter int ADDR     = 5,
  parameter int OUT_REG  = 0,
  parameter int RDW_MODE = 0
) (
  input  logic                clK,
  input  logic                rst,
  input  logic                a_port_EN,
  input  logic                a_port_WR,
  input  logic [DATA/8-1:0]   a_port_BE,
  input  logic [ADDR-1:0]     a_port_ADDR,
  input  logic [DATA-1:0]     a_port_data_IN,
  output logic [DATA-1:0]     a_port_data_OUT,
  output logic                a_port_VLD,
  input  logic                b_port_EN,
  input  logic                b_port_WR,
  input  logic [DATA/8-1:0]   b_port_BE,
  input  logic [ADDR-1:0]     b_port_ADDR,
  input  logic [DATA-1:0]     b_port_data_IN,
  output logic [DATA-1:0]     b_port_data_OUT,
  output logic                b_port_VLD,
  input  logic                clr_REQ,
  output logic                clr_BUSY
`ifdef DPRAM_BE_COLL_DET_EN
  ,
  output logic                coll_FLAG
`endif
);

  localparam int BYTES = DATA / 8;
  localparam int DEPTH = 1 << ADDR;
  localparam bit WRITE_FIRST = (RDW_MODE != 0);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t          state_reg, state_next;
  logic [ADDR-1:0] sweep_cnt_reg, sweep_cnt_next;
  logic            clr_busy;
  logic            sweep_we;

  // Clear sweep FSM: state register
  always_ff @(posedge clK or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      sweep_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      sweep_cnt_reg <= sweep_cnt_next;
    end
  end

  // Clear sweep FSM: next state
  always_comb begin
    state_next     = state_reg;
    sweep_cnt_next = sweep_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (clr_REQ) begin
          state_next     = SWEEP;
          sweep_cnt_next = '0;
        end
      end
      SWEEP: begin
        sweep_cnt_next = sweep_cnt_reg + ADDR'(1);
        if (&sweep_cnt_reg) begin
          state_next     = IDLE;
          sweep_cnt_next = '0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Clear sweep FSM: outputs
  always_comb begin
    clr_busy = (state_reg == SWEEP);
    sweep_we = (state_reg == SWEEP);
  end

  assign clr_BUSY = clr_busy;

  // Index 0 is port A, index 1 is port B.
  logic [1:0]        port_en, port_wr;
  logic [BYTES-1:0]  port_be   [2];
  logic [ADDR-1:0]   port_addr [2];
  logic [DATA-1:0]   port_din  [2];

  assign port_en      = {b_port_EN, a_port_EN};
  assign port_wr      = {b_port_WR, a_port_WR};
  assign port_be[0]   = a_port_BE;
  assign port_be[1]   = b_port_BE;
  assign port_addr[0] = a_port_ADDR;
  assign port_addr[1] = b_port_ADDR;
  assign port_din[0]  = a_port_data_IN;
  assign port_din[1]  = b_port_data_IN;

  logic [1:0]        acc, wr_any;
  logic [BYTES-1:0]  we [2];
  logic              same_addr;
  logic [DATA-1:0]   dout [2];
  logic [1:0]        vld;

  logic [DATA-1:0]   mem [DEPTH];

  assign same_addr = acc[0] & acc[1] & (port_addr[0] == port_addr[1]);

  // Port B lanes are written first so port A wins any byte both ports enable.
  always_ff @(posedge clK) begin
    if (sweep_we) begin
      mem[sweep_cnt_reg] <= '0;
    end
    for (int i = 0; i < BYTES; i++) begin
      if (we[1][i]) mem[port_addr[1]][8*i +: 8] <= port_din[1][8*i +: 8];
      if (we[0][i]) mem[port_addr[0]][8*i +: 8] <= port_din[0][8*i +: 8];
    end
  end

  generate
    for (genvar gp = 0; gp < 2; gp++) begin : g_port
      localparam bit OWN_A = (gp == 0);

      logic [BYTES-1:0] sel;
      logic [DATA-1:0]  dat;
      logic [DATA-1:0]  ram_q;
      logic             vld1_reg;
      logic [BYTES-1:0] sel1_reg;
      logic [DATA-1:0]  ovr1_reg;
      logic [DATA-1:0]  word1;

      assign acc[gp]    = port_en[gp] & ~clr_busy & ~rst;
      assign we[gp]     = {BYTES{acc[gp] & port_wr[gp]}} & port_be[gp];
      assign wr_any[gp] = |we[gp];

      // Write-first returns the merged word; lanes the RAM read cannot see yet
      // are patched from the write data of whichever port owns that byte.
      for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
        logic a_hit, b_hit;
        assign a_hit   = we[0][gi] & (OWN_A | same_addr);
        assign b_hit   = we[1][gi] & (~OWN_A | same_addr);
        assign sel[gi] = WRITE_FIRST & wr_any[gp] & (a_hit | b_hit);
        assign dat[8*gi +: 8] = a_hit ? port_din[0][8*gi +: 8] : port_din[1][8*gi +: 8];
        assign word1[8*gi +: 8] = sel1_reg[gi] ? ovr1_reg[8*gi +: 8] : ram_q[8*gi +: 8];
      end

      always_ff @(posedge clK) begin
        if (acc[gp]) ram_q <= mem[port_addr[gp]];
      end

      always_ff @(posedge clK or posedge rst) begin
        if (rst) begin
          vld1_reg <= 1'b0;
          sel1_reg <= '0;
          ovr1_reg <= '0;
        end else begin
          vld1_reg <= acc[gp];
          if (acc[gp]) begin
            sel1_reg <= sel;
            ovr1_reg <= dat;
          end
        end
      end

      if (OUT_REG != 0) begin : g_oreg
        logic [DATA-1:0] dout_reg;
        logic            vld2_reg;
        always_ff @(posedge clK or posedge rst) begin
          if (rst) begin
            dout_reg <= '0;
            vld2_reg <= 1'b0;
          end else begin
            vld2_reg <= vld1_reg;
            if (vld1_reg) dout_reg <= word1;
          end
        end
        assign dout[gp] = dout_reg;
        assign vld[gp]  = vld2_reg;
      end else begin : g_hold
        // Hold register keeps the last returned word between strobes.
        logic [DATA-1:0] hold_reg;
        always_ff @(posedge clK or posedge rst) begin
          if (rst) begin
            hold_reg <= '0;
          end else if (vld1_reg) begin
            hold_reg <= word1;
          end
        end
        assign dout[gp] = vld1_reg ? word1 : hold_reg;
        assign vld[gp]  = vld1_reg;
      end
    end
  endgenerate

  assign a_port_data_OUT = dout[0];
  assign b_port_data_OUT = dout[1];
  assign a_port_VLD      = vld[0];
  assign b_port_VLD      = vld[1];

`ifdef DPRAM_BE_COLL_DET_EN
  logic coll_reg;
  always_ff @(posedge clK or posedge rst) begin
    if (rst) begin
      coll_reg <= 1'b0;
    end else begin
      coll_reg <= same_addr & (|(acc & port_wr));
    end
  end
  assign coll_FLAG = coll_reg;
`endif

endmodule

// File: tb/tb_dpram_be.sv
// Bench for dpram_be: two configurations (1-cycle read-first, 2-cycle
// write-first) share one stimulus and are checked against a word-level model.
module tb_dpram_be;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  en  = '0;
  logic [1:0]  wr  = '0;
  logic [3:0]  be   [2];
  logic [4:0]  addr [2];
  logic [31:0] din  [2];
  logic        clr = 1'b0;

  logic [31:0] d0_dat [2];
  logic [31:0] d1_dat [2];
  logic [1:0]  d0_vld, d1_vld;
  logic        d0_busy, d1_busy;
`ifdef DPRAM_BE_COLL_DET_EN
  logic        d0_coll, d1_coll;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;
  int n;

  initial begin
    forever #5 clk = ~clk;
  end

  dpram_be #(.DATA(32), .ADDR(5), .OUT_REG(0), .RDW_MODE(0)) dut0 (
    .clK(clk), .rst(rst),
    .a_port_EN(en[0]), .a_port_WR(wr[0]), .a_port_BE(be[0]), .a_port_ADDR(addr[0]),
    .a_port_data_IN(din[0]), .a_port_data_OUT(d0_dat[0]), .a_port_VLD(d0_vld[0]),
    .b_port_EN(en[1]), .b_port_WR(wr[1]), .b_port_BE(be[1]), .b_port_ADDR(addr[1]),
    .b_port_data_IN(din[1]), .b_port_data_OUT(d0_dat[1]), .b_port_VLD(d0_vld[1]),
    .clr_REQ(clr), .clr_BUSY(d0_busy)
`ifdef DPRAM_BE_COLL_DET_EN
    , .coll_FLAG(d0_coll)
`endif
  );

  dpram_be #(.DATA(32), .ADDR(5), .OUT_REG(1), .RDW_MODE(1)) dut1 (
    .clK(clk), .rst(rst),
    .a_port_EN(en[0]), .a_port_WR(wr[0]), .a_port_BE(be[0]), .a_port_ADDR(addr[0]),
    .a_port_data_IN(din[0]), .a_port_data_OUT(d1_dat[0]), .a_port_VLD(d1_vld[0]),
    .b_port_EN(en[1]), .b_port_WR(wr[1]), .b_port_BE(be[1]), .b_port_ADDR(addr[1]),
    .b_port_data_IN(din[1]), .b_port_data_OUT(d1_dat[1]), .b_port_VLD(d1_vld[1]),
    .clr_REQ(clr), .clr_BUSY(d1_busy)
`ifdef DPRAM_BE_COLL_DET_EN
    , .coll_FLAG(d1_coll)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    else pass_cnt++;
  endtask

  // ---------------- word-level model ----------------
  logic [31:0] m [32];
  int          sweep_left = 0;
  logic [4:0]  sweep_addr = '0;
  logic        m_busy;
  logic [1:0]  m_acc, m_wr;
  logic [31:0] m_old [2];
  logic [31:0] e0_dat [2] = '{32'h0, 32'h0};
  logic [31:0] e1_dat [2] = '{32'h0, 32'h0};
  logic [31:0] p1_dat [2] = '{32'h0, 32'h0};
  logic [1:0]  e0_vld = '0, e1_vld = '0, p1_vld = '0;
  logic        e_busy = 1'b0;
`ifdef DPRAM_BE_COLL_DET_EN
  logic        e_coll = 1'b0;
`endif

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sweep_left = 0;
      sweep_addr = '0;
      e_busy = 1'b0;
      e0_vld = '0; e1_vld = '0; p1_vld = '0;
      for (int p = 0; p < 2; p++) begin
        e0_dat[p] = '0; e1_dat[p] = '0; p1_dat[p] = '0;
      end
`ifdef DPRAM_BE_COLL_DET_EN
      e_coll = 1'b0;
`endif
    end else begin
      m_busy = (sweep_left > 0);
      for (int p = 0; p < 2; p++) begin
        m_acc[p] = en[p] && !m_busy;
        m_wr[p]  = m_acc[p] && wr[p];
        m_old[p] = m[addr[p]];
      end
`ifdef DPRAM_BE_COLL_DET_EN
      e_coll = m_acc[0] && m_acc[1] && (addr[0] == addr[1]) && (m_wr[0] || m_wr[1]);
`endif
      if (m_busy) begin
        m[sweep_addr] = '0;
        sweep_addr = sweep_addr + 5'd1;
        sweep_left--;
      end else if (clr) begin
        sweep_left = 32;
        sweep_addr = '0;
      end
      // A applied last: it owns bytes both ports enable
      for (int p = 1; p >= 0; p--)
        if (m_wr[p])
          for (int i = 0; i < 4; i++)
            if (be[p][i]) m[addr[p]][8*i +: 8] = din[p][8*i +: 8];
      for (int p = 0; p < 2; p++) begin
        e0_vld[p] = m_acc[p];
        if (m_acc[p]) e0_dat[p] = m_old[p];
        e1_vld[p] = p1_vld[p];
        if (p1_vld[p]) e1_dat[p] = p1_dat[p];
        p1_vld[p] = m_acc[p];
        if (m_acc[p]) p1_dat[p] = (m_wr[p] && be[p] != 4'h0) ? m[addr[p]] : m_old[p];
      end
      e_busy = (sweep_left > 0);
    end
  end

  always @(negedge clk) begin
    for (int p = 0; p < 2; p++) begin
      chk(p == 0 ? "d0_a_vld" : "d0_b_vld", 32'(d0_vld[p]), 32'(e0_vld[p]));
      chk(p == 0 ? "d0_a_dat" : "d0_b_dat", d0_dat[p], e0_dat[p]);
      chk(p == 0 ? "d1_a_vld" : "d1_b_vld", 32'(d1_vld[p]), 32'(e1_vld[p]));
      chk(p == 0 ? "d1_a_dat" : "d1_b_dat", d1_dat[p], e1_dat[p]);
    end
    chk("d0_busy", 32'(d0_busy), 32'(e_busy));
    chk("d1_busy", 32'(d1_busy), 32'(e_busy));
`ifdef DPRAM_BE_COLL_DET_EN
    chk("d0_coll", 32'(d0_coll), 32'(e_coll));
    chk("d1_coll", 32'(d1_coll), 32'(e_coll));
`endif
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic port(input int p, input logic w, input logic [3:0] b,
                      input logic [4:0] a, input logic [31:0] d);
    en[p] = 1'b1; wr[p] = w; be[p] = b; addr[p] = a; din[p] = d;
    $display("txn t=%0t port%s %s addr=%0d be=%h data=%h", $time, p == 0 ? "A" : "B",
             w ? "wr" : "rd", a, b, d);
  endtask

  task automatic idle();
    en = '0; wr = '0; clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int p = 0; p < 2; p++) begin
      be[p] = '0; addr[p] = '0; din[p] = '0;
    end
    #1 rst = 1'b1;
    tick(); tick();
    chk("rst_a_dat", d0_dat[0], 32'h0);
    chk("rst_vld", 32'(d1_vld), 32'h0);
    chk("rst_busy", 32'(d0_busy), 32'h0);
    rst = 1'b0;

    // Initial clear puts the array in a known state
    $display("txn t=%0t clear", $time);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("clr_busy_start", 32'(d0_busy), 32'h1);
    n = 0;
    while (d0_busy && n < 40) begin n++; tick(); end
    chk("clr_busy_len", n, 32);

    // Full write then read-back
    port(0, 1'b1, 4'hF, 5'd3, 32'hDEADBEEF); tick();
    port(0, 1'b0, 4'h0, 5'd3, 32'h0); tick();
    chk("wr_rd_vld", 32'(d0_vld[0]), 32'h1);
    chk("wr_rd_dat", d0_dat[0], 32'hDEADBEEF);
    idle(); tick();
    chk("hold_dat", d0_dat[0], 32'hDEADBEEF);
    chk("hold_vld", 32'(d0_vld[0]), 32'h0);

    // Partial write: read-first vs write-first
    port(0, 1'b1, 4'h5, 5'd3, 32'h11223344); tick();
    chk("rdw_read_first", d0_dat[0], 32'hDEADBEEF);
    port(0, 1'b0, 4'h0, 5'd3, 32'h0); tick();
    chk("be_readback", d0_dat[0], 32'hDE22BE44);
    chk("rdw_write_first", d1_dat[0], 32'hDE22BE44);
    idle(); tick(); tick();

    // Cross-port collisions on word 7
    port(0, 1'b1, 4'h3, 5'd7, 32'hAAAAAAAA);
    port(1, 1'b1, 4'h6, 5'd7, 32'hBBBBBBBB); tick();
`ifdef DPRAM_BE_COLL_DET_EN
    chk("coll_pulse", 32'(d0_coll), 32'h1);
`endif
    port(0, 1'b0, 4'h0, 5'd7, 32'h0);
    port(1, 1'b1, 4'hF, 5'd7, 32'h12345678); tick();
    chk("coll_merge", d0_dat[0], 32'h00BBAAAA);
    idle(); tick();
    chk("coll_rd_old_wf", d1_dat[0], 32'h00BBAAAA);
    chk("coll_wr_wf", d1_dat[1], 32'h12345678);
`ifdef DPRAM_BE_COLL_DET_EN
    chk("coll_drop", 32'(d0_coll), 32'h0);
`endif
    tick();

    // Byte enables all zero with WR=1 still strobes VLD
    port(0, 1'b1, 4'h0, 5'd7, 32'hFFFFFFFF); tick();
    chk("be0_vld", 32'(d0_vld[0]), 32'h1);
    chk("be0_dat", d0_dat[0], 32'h12345678);
    idle();

    // Two-cycle latency, back-to-back reads
    for (int i = 0; i < 4; i++) begin
      port(1, 1'b1, 4'hF, 5'(i), 32'hA0000000 + 32'(i)); tick();
    end
    idle(); tick(); tick();
    for (int k = 0; k < 7; k++) begin
      idle();
      if (k < 4) port(0, 1'b0, 4'h0, 5'(k), 32'h0);
      tick();
      chk("oreg_vld", 32'(d1_vld[0]), (k >= 1 && k <= 4) ? 32'h1 : 32'h0);
      if (k >= 1 && k <= 4) chk("oreg_dat", d1_dat[0], 32'hA0000000 + 32'(k - 1));
    end

    // Fill, then clear with a same-cycle read and discarded requests
    for (int i = 0; i < 16; i++) begin
      port(0, 1'b1, 4'hF, 5'(2*i), 32'hC0DE0000 + 32'(2*i));
      port(1, 1'b1, 4'hF, 5'(2*i+1), 32'hC0DE0000 + 32'(2*i+1));
      tick();
    end
    idle();
    clr = 1'b1;
    port(0, 1'b0, 4'h0, 5'd4, 32'h0); tick();
    clr = 1'b0;
    chk("clr_same_cycle_vld", 32'(d0_vld[0]), 32'h1);
    chk("clr_same_cycle_dat", d0_dat[0], 32'hC0DE0004);
    port(0, 1'b1, 4'hF, 5'd5, 32'hFFFFFFFF);
    port(1, 1'b0, 4'h0, 5'd6, 32'h0);
    n = 0;
    while (d0_busy && n < 40) begin
      n++; tick();
      if (n == 5) chk("sweep_no_vld", 32'(d0_vld), 32'h0);
    end
    chk("sweep_len", n, 32);
    idle();
    for (int i = 0; i < 32; i++) begin
      port(0, 1'b0, 4'h0, 5'(i), 32'h0);
      port(1, 1'b0, 4'h0, 5'(31 - i), 32'h0);
      tick();
      if (i == 5) chk("cleared_word5", d0_dat[0], 32'h0);
    end
    idle();

    // Refill, then reset after ten sweep cycles
    for (int i = 0; i < 32; i++) begin
      port(0, 1'b1, 4'hF, 5'(i), 32'h5A000000 + 32'(i)); tick();
    end
    idle();
    clr = 1'b1; tick(); clr = 1'b0;
    repeat (10) tick();
    $display("txn t=%0t reset mid-sweep", $time);
    rst = 1'b1;
    tick();
    chk("abort_busy", 32'(d0_busy), 32'h0);
    chk("abort_dat", d0_dat[0], 32'h0);
    tick();
    rst = 1'b0;
    port(0, 1'b0, 4'h0, 5'd9, 32'h0);
    port(1, 1'b0, 4'h0, 5'd10, 32'h0);
    tick();
    chk("abort_word9", d0_dat[0], 32'h0);
    chk("abort_word10", d0_dat[1], 32'h5A00000A);
    for (int i = 0; i < 32; i++) begin
      port(0, 1'b0, 4'h0, 5'(i), 32'h0);
      idle(); en[0] = 1'b1;
      tick();
    end
    idle(); tick(); tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
